ebpc_stream_merger: RTL and testbench
=====================================

EBPC_STREAM_MERGER -- requirements
Module: ebpc_stream_merger

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, max words per burst; legal range 1..2**(DATA_W-1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, words per input FIFO; power of two, >= BURST_LEN.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports znz_data_i in DATA_W, znz_vld_i in 1, znz_rdy_o out 1; the encoder ZNZ stream.
REQ-006 SHALL have ports bpc_data_i in DATA_W, bpc_vld_i in 1, bpc_rdy_o out 1; the encoder BPC stream.
REQ-007 SHALL have port flush_i  in  1  end-of-tensor; held high from after the last input word until flush_done_o.
REQ-008 SHALL have ports data_o out DATA_W, vld_o out 1, rdy_i in 1, last_o out 1; the merged output stream.
REQ-009 SHALL have port flush_done_o  out  1  one-cycle pulse after the word carrying last_o is accepted.

Function
REQ-010 SHALL buffer each input stream in its own FIFO; rdy_o = FIFO not full; a word is accepted when vld & rdy.
REQ-011 SHALL emit bursts: one header word, then N body words from a single FIFO, 1 <= N <= BURST_LEN.
REQ-012 SHALL encode the header as bit DATA_W-1 = source (0 = ZNZ, 1 = BPC) and bits DATA_W-2:0 = N-1.
REQ-013 SHALL implement FSM states ARB, HDR, BODY, DONE.
REQ-014 ARB, flush_i low: SHALL pick a FIFO holding >= BURST_LEN words, with N = BURST_LEN.
REQ-015 ARB, flush_i high: SHALL pick any non-empty FIFO, with N = min(fill, BURST_LEN).
REQ-016 SHALL arbitrate round-robin between the two FIFOs; ZNZ has priority after reset; the last-served source loses a tie.
REQ-017 SHALL latch source and N on ARB->HDR; ARB SHALL take one cycle and drive vld_o low.
REQ-018 HDR: SHALL drive vld_o with the header; on rdy_i go to BODY.
REQ-019 BODY: SHALL present FIFO head with vld_o; each handshake pops one word and decrements the counter; after the Nth word go to ARB.
REQ-020 SHALL hold data_o and vld_o stable while vld_o & !rdy_i.
REQ-021 SHALL assert last_o on the Nth body word iff flush_i is high at latch and both FIFOs hold no further words beyond this burst.
REQ-022 After the last_o handshake SHALL enter DONE, pulse flush_done_o for one cycle, then return to ARB.
REQ-023 Flush with both FIFOs already empty and no burst pending: SHALL emit a single header 0x00 with last_o, which is a zero-payload terminator; then DONE.
REQ-024 Simultaneous push and pop on one FIFO SHALL keep its fill unchanged; a full FIFO that is popped SHALL accept in the same cycle.
REQ-025 Throughput in BODY SHALL be 1 word/cycle when rdy_i stays high; latency from input word to its output slot is >= 3 cycles.

Reset
REQ-026 On rst_ni low SHALL asynchronously clear FIFOs, counters and round-robin pointer, and set FSM to ARB.
REQ-027 During reset SHALL drive vld_o=0, last_o=0, data_o=0, flush_done_o=0, znz_rdy_o=0, bpc_rdy_o=0.
REQ-028 Reset mid-burst SHALL discard all buffered data; no partial burst is resumed.

Configuration
REQ-029 Macro EBPC_MERGER_STATS_EN defined: SHALL add outputs znz_bursts_o and bpc_bursts_o (16 b each), counting header handshakes per source, saturating, cleared by reset.
REQ-030 Without EBPC_MERGER_STATS_EN the counters and ports SHALL be absent; function is otherwise identical.

Structure
REQ-031 DATA_W, the header bit positions and the FSM state enum SHALL live in ebpc_pkg.
REQ-032 SHALL instantiate sub-module ebpc_merger_fifo twice (parameters DATA_W, FIFO_DEPTH; ports push, pop, full, empty, fill count).

Verification
REQ-033 Stimulus: 8 ZNZ words 0x01..0x08, flush low, rdy_i=1. Response: 0x07, then 0x01..0x08; no BPC burst.
REQ-034 Stimulus: 8 ZNZ and 8 BPC words arrive together. Response: ZNZ burst (header 0x07), then BPC burst (header 0x87).
REQ-035 Stimulus: 3 BPC words 0xA0..0xA2, then flush_i. Response: 0x82, 0xA0, 0xA1, 0xA2 with last_o on 0xA2; flush_done_o pulses once.
REQ-036 Stimulus: flush_i with both FIFOs empty. Response: single 0x00 with last_o, then flush_done_o.
REQ-037 Stimulus: random rdy_i stalls with both FIFOs full. Response: data_o is stable while stalled, no word is lost or duplicated, and reassembled streams match the encoder expresp files.
REQ-038 Stimulus: rst_ni pulsed low mid-BODY. Response: all outputs 0 immediately; the next burst starts with a header.

Source files
------------

// File: rtl/ebpc_pkg.sv
// Shared definitions for the EBPC stream merger: word width, header layout,
// FSM state encoding and small helper functions.
package ebpc_pkg;

    localparam int DATA_W      = 8;
    localparam int HDR_SRC_BIT = DATA_W - 1;
    localparam int HDR_LEN_W   = DATA_W - 1;
    localparam int STAT_W      = 16;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        SRC_ZNZ = 1'b0,
        SRC_BPC = 1'b1
    } src_e;

    function automatic logic [DATA_W-1:0] make_hdr(input src_e src, input logic [HDR_LEN_W-1:0] len_m1);
        logic [DATA_W-1:0] hdr;
        hdr                    = '0;
        hdr[HDR_SRC_BIT]       = src;
        hdr[HDR_LEN_W-1:0]     = len_m1;
        return hdr;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ebpc_merger_fifo.sv
// Single-clock FIFO with fill count; a pop on a full FIFO frees the slot for
// a push in the same cycle. FIFO_DEPTH must be a power of two (>= 2).
module ebpc_merger_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] fill_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic              do_push, do_pop;

    assign full_o  = (fill_q == DEPTH_C);
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage carries no reset; pointers and fill define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ebpc_stream_merger.sv
// Merges the ZNZ and BPC encoder streams into one stream of header+body bursts.
// Optional EBPC_MERGER_STATS_EN adds saturating per-source burst counters.
module ebpc_stream_merger
    import ebpc_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] znz_data_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    input  logic              flush_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              last_o,
    output logic              flush_done_o
`ifdef EBPC_MERGER_STATS_EN
    ,
    output logic [STAT_W-1:0] znz_bursts_o,
    output logic [STAT_W-1:0] bpc_bursts_o
`endif
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FW-1:0] BL_C  = FW'(BURST_LEN);
    localparam logic [FW-1:0] ONE_C = FW'(1);

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    src_e              prio_q, prio_d;
    logic [FW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              term_q, term_d;

    logic [DATA_W-1:0] z_head, b_head;
    logic              z_full, b_full, z_empty, b_empty;
    logic [FW-1:0]     z_fill, b_fill;
    logic              z_push, b_push, z_pop, b_pop;

    logic              z_ok, b_ok;
    src_e              sel_src;
    logic [FW-1:0]     sel_fill, burst_n;
    logic              other_empty;

    // Ready is held low while in reset; a pop on a full FIFO frees a slot at once.
    assign znz_rdy_o = rst_ni & (~z_full | z_pop);
    assign bpc_rdy_o = rst_ni & (~b_full | b_pop);
    assign z_push    = znz_vld_i & znz_rdy_o;
    assign b_push    = bpc_vld_i & bpc_rdy_o;

    ebpc_merger_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_znz_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (z_push),
        .data_i  (znz_data_i),
        .pop_i   (z_pop),
        .data_o  (z_head),
        .full_o  (z_full),
        .empty_o (z_empty),
        .fill_o  (z_fill)
    );

    ebpc_merger_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_bpc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (b_push),
        .data_i  (bpc_data_i),
        .pop_i   (b_pop),
        .data_o  (b_head),
        .full_o  (b_full),
        .empty_o (b_empty),
        .fill_o  (b_fill)
    );

    // Full bursts only in normal operation; any remainder once flushing.
    assign z_ok        = flush_i ? ~z_empty : (z_fill >= BL_C);
    assign b_ok        = flush_i ? ~b_empty : (b_fill >= BL_C);
    assign sel_src     = (z_ok && b_ok) ? prio_q : (z_ok ? SRC_ZNZ : SRC_BPC);
    assign sel_fill    = (sel_src == SRC_ZNZ) ? z_fill : b_fill;
    assign other_empty = (sel_src == SRC_ZNZ) ? b_empty : z_empty;
    assign burst_n     = (flush_i && (sel_fill < BL_C)) ? sel_fill : BL_C;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        term_d       = term_q;
        vld_o        = 1'b0;
        data_o       = '0;
        last_o       = 1'b0;
        flush_done_o = 1'b0;
        z_pop        = 1'b0;
        b_pop        = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (z_ok || b_ok) begin
                    src_d   = sel_src;
                    cnt_d   = burst_n;
                    last_d  = flush_i & (sel_fill == burst_n) & other_empty;
                    term_d  = 1'b0;
                    prio_d  = (sel_src == SRC_ZNZ) ? SRC_BPC : SRC_ZNZ;
                    state_d = ST_HDR;
                end else if (flush_i) begin
                    // Nothing left to send: emit a zero-payload terminator header.
                    src_d   = SRC_ZNZ;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                    term_d  = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                vld_o  = 1'b1;
                data_o = term_q ? '0 : make_hdr(src_q, HDR_LEN_W'(cnt_q - ONE_C));
                last_o = term_q;
                if (rdy_i) begin
                    state_d = term_q ? ST_DONE : ST_BODY;
                end
            end
            ST_BODY: begin
                vld_o  = 1'b1;
                data_o = (src_q == SRC_ZNZ) ? z_head : b_head;
                last_o = last_q & (cnt_q == ONE_C);
                if (rdy_i) begin
                    z_pop = (src_q == SRC_ZNZ);
                    b_pop = (src_q == SRC_BPC);
                    cnt_d = cnt_q - ONE_C;
                    if (cnt_q == ONE_C) begin
                        state_d = last_q ? ST_DONE : ST_ARB;
                    end
                end
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ARB;
            src_q   <= SRC_ZNZ;
            prio_q  <= SRC_ZNZ;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            term_q  <= term_d;
        end
    end

`ifdef EBPC_MERGER_STATS_EN
    logic              hdr_hs;
    logic [STAT_W-1:0] znz_bursts_q, bpc_bursts_q;

    // The terminator header is not a burst and is not counted.
    assign hdr_hs       = (state_q == ST_HDR) & rdy_i & ~term_q;
    assign znz_bursts_o = znz_bursts_q;
    assign bpc_bursts_o = bpc_bursts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            znz_bursts_q <= '0;
            bpc_bursts_q <= '0;
        end else if (hdr_hs) begin
            if (src_q == SRC_ZNZ) begin
                znz_bursts_q <= sat_inc(znz_bursts_q);
            end else begin
                bpc_bursts_q <= sat_inc(bpc_bursts_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ebpc_stream_merger.sv
// Bench for ebpc_stream_merger: directed vector table, mid-burst reset and a
// randomized stall run checked by reassembling bursts into the source streams.
module tb_ebpc_stream_merger;
    import ebpc_pkg::*;

    localparam int BL = 8;
    localparam int FD = 16;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [DATA_W-1:0] znz_data_i, bpc_data_i, data_o;
    logic              znz_vld_i, znz_rdy_o, bpc_vld_i, bpc_rdy_o;
    logic              flush_i, vld_o, rdy_i, last_o, flush_done_o;

    always #5 clk = ~clk;

    ebpc_stream_merger #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .znz_data_i   (znz_data_i),
        .znz_vld_i    (znz_vld_i),
        .znz_rdy_o    (znz_rdy_o),
        .bpc_data_i   (bpc_data_i),
        .bpc_vld_i    (bpc_vld_i),
        .bpc_rdy_o    (bpc_rdy_o),
        .flush_i      (flush_i),
        .data_o       (data_o),
        .vld_o        (vld_o),
        .rdy_i        (rdy_i),
        .last_o       (last_o),
        .flush_done_o (flush_done_o)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] out_q[$];
    logic [7:0] zq[$], bq[$];
    int         fd_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    typedef struct {
        int         nz;
        logic [7:0] zb;
        int         nb;
        logic [7:0] bb;
        bit         flush;
        int         off;
        int         len;
    } vec_t;

    vec_t       vec[5];
    logic [8:0] exp_w[64];
    int         n_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic add(input logic last, input logic [7:0] d);
        exp_w[n_exp] = {last, d};
        n_exp++;
    endtask

    // Output monitor: records accepted words and checks hold-while-stalled.
    always @(negedge clk) begin
        #2;
        if (rst_ni) begin
            if (stall_prev) begin
                chk("stall_vld", {31'd0, vld_o}, 32'd1);
                chk("stall_data", {24'd0, data_o}, {24'd0, stall_data});
            end
            if (vld_o && rdy_i) out_q.push_back({last_o, data_o});
            if (flush_done_o) fd_cnt++;
            stall_prev = vld_o && !rdy_i;
            stall_data = data_o;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_ni    = 1'b0;
        znz_vld_i = 1'b1;
        bpc_vld_i = 1'b1;
        flush_i   = 1'b0;
        rdy_i     = 1'b1;
        #1;
        chk("rst_vld", {31'd0, vld_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_last", {31'd0, last_o}, 32'd0);
        chk("rst_fdone", {31'd0, flush_done_o}, 32'd0);
        chk("rst_zrdy", {31'd0, znz_rdy_o}, 32'd0);
        chk("rst_brdy", {31'd0, bpc_rdy_o}, 32'd0);
        znz_vld_i  = 1'b0;
        bpc_vld_i  = 1'b0;
        znz_data_i = '0;
        bpc_data_i = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        out_q.delete();
        fd_cnt = 0;
    endtask

    task automatic push_streams(input int z0, input int z1, input int b0, input int b1, input bit rnd);
        int zi, bi, guard;
        zi = z0; bi = b0; guard = 0;
        while ((zi < z1 || bi < b1) && guard < 5000) begin
            @(negedge clk);
            znz_vld_i  = (zi < z1) && (!rnd || $urandom_range(0, 3) != 0);
            bpc_vld_i  = (bi < b1) && (!rnd || $urandom_range(0, 3) != 0);
            znz_data_i = (zi < z1) ? zq[zi] : 8'h00;
            bpc_data_i = (bi < b1) ? bq[bi] : 8'h00;
            if (rnd) rdy_i = ($urandom_range(0, 2) != 0);
            #1;
            if (znz_vld_i && znz_rdy_o) zi++;
            if (bpc_vld_i && bpc_rdy_o) bi++;
            guard++;
        end
        if (guard >= 5000) chk("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
        znz_vld_i = 1'b0;
        bpc_vld_i = 1'b0;
    endtask

    task automatic flush_wait(input bit rnd);
        bit seen;
        seen    = 1'b0;
        flush_i = 1'b1;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (rnd) rdy_i = ($urandom_range(0, 2) != 0);
            #1;
            if (flush_done_o) seen = 1'b1;
        end
        chk("flush_done_seen", {31'd0, seen}, 32'd1);
        flush_i = 1'b0;
        rdy_i   = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Splits the captured output into bursts and rebuilds each source stream.
    task automatic reassemble_check();
        logic [7:0] gz[$], gb[$];
        logic [8:0] hdr, w;
        int         i, n, mism;
        i = 0;
        while (i < out_q.size()) begin
            hdr = out_q[i];
            i++;
            if (hdr[8]) begin
                chk("term_hdr", {24'd0, hdr[7:0]}, 32'd0);
                chk("term_is_final", i, out_q.size());
            end else begin
                n = int'(hdr[6:0]) + 1;
                if (n > BL) chk("burst_len_max", n, BL);
                for (int k = 0; k < n && i < out_q.size(); k++) begin
                    w = out_q[i];
                    i++;
                    if (w[8]) chk("last_only_final", i, out_q.size());
                    if (hdr[7]) gb.push_back(w[7:0]);
                    else        gz.push_back(w[7:0]);
                end
            end
        end
        chk("znz_count", gz.size(), zq.size());
        chk("bpc_count", gb.size(), bq.size());
        mism = 0;
        for (int k = 0; k < zq.size(); k++) if (k >= gz.size() || gz[k] !== zq[k]) mism++;
        for (int k = 0; k < bq.size(); k++) if (k >= gb.size() || gb[k] !== bq[k]) mism++;
        chk("stream_words", mism, 0);
        if (out_q.size() > 0) chk("final_last", {31'd0, out_q[out_q.size()-1][8]}, 32'd1);
        else chk("rand_output_present", 32'd0, 32'd1);
        chk("rand_fdone_count", fd_cnt, 1);
    endtask

    initial begin
        rst_ni     = 1'b0;
        znz_vld_i  = 1'b0;
        bpc_vld_i  = 1'b0;
        znz_data_i = '0;
        bpc_data_i = '0;
        flush_i    = 1'b0;
        rdy_i      = 1'b1;

        // Directed table: inputs and the exact expected output word list.
        vec[0] = '{nz: 8, zb: 8'h01, nb: 0, bb: 8'h00, flush: 0, off: n_exp, len: 0};
        add(0, 8'h07);
        for (int k = 0; k < 8; k++) add(0, 8'(8'h01 + k));
        vec[0].len = n_exp - vec[0].off;

        vec[1] = '{nz: 8, zb: 8'h10, nb: 8, bb: 8'h20, flush: 0, off: n_exp, len: 0};
        add(0, 8'h07);
        for (int k = 0; k < 8; k++) add(0, 8'(8'h10 + k));
        add(0, 8'h87);
        for (int k = 0; k < 8; k++) add(0, 8'(8'h20 + k));
        vec[1].len = n_exp - vec[1].off;

        vec[2] = '{nz: 0, zb: 8'h00, nb: 3, bb: 8'hA0, flush: 1, off: n_exp, len: 0};
        add(0, 8'h82); add(0, 8'hA0); add(0, 8'hA1); add(1, 8'hA2);
        vec[2].len = n_exp - vec[2].off;

        vec[3] = '{nz: 0, zb: 8'h00, nb: 0, bb: 8'h00, flush: 1, off: n_exp, len: 0};
        add(1, 8'h00);
        vec[3].len = n_exp - vec[3].off;

        vec[4] = '{nz: 10, zb: 8'h30, nb: 0, bb: 8'h00, flush: 1, off: n_exp, len: 0};
        add(0, 8'h07);
        for (int k = 0; k < 8; k++) add(0, 8'(8'h30 + k));
        add(0, 8'h01); add(0, 8'h38); add(1, 8'h39);
        vec[4].len = n_exp - vec[4].off;

        for (int v = 0; v < 5; v++) begin
            do_reset();
            zq.delete(); bq.delete();
            for (int k = 0; k < vec[v].nz; k++) zq.push_back(8'(vec[v].zb + k));
            for (int k = 0; k < vec[v].nb; k++) bq.push_back(8'(vec[v].bb + k));
            push_streams(0, vec[v].nz, 0, vec[v].nb, 1'b0);
            if (vec[v].flush) flush_wait(1'b0);
            else repeat (40) @(negedge clk);
            chk($sformatf("v%0d_len", v), out_q.size(), vec[v].len);
            for (int k = 0; k < vec[v].len; k++)
                chk($sformatf("v%0d_w%0d", v, k), (k < out_q.size()) ? {23'd0, out_q[k]} : 32'hDEAD,
                    {23'd0, exp_w[vec[v].off + k]});
            chk($sformatf("v%0d_fdone", v), fd_cnt, vec[v].flush ? 1 : 0);
        end

        // Both sources arriving together with mixed fill at flush.
        do_reset();
        zq.delete(); bq.delete();
        for (int k = 0; k < 3; k++) zq.push_back(8'(8'h40 + k));
        for (int k = 0; k < 2; k++) bq.push_back(8'(8'h50 + k));
        push_streams(0, 3, 0, 2, 1'b0);
        flush_wait(1'b0);
        chk("mix_len", out_q.size(), 7);
        if (out_q.size() == 7) begin
            chk("mix_h0", {23'd0, out_q[0]}, 32'h002);
            chk("mix_w3", {23'd0, out_q[3]}, 32'h042);
            chk("mix_h1", {23'd0, out_q[4]}, 32'h081);
            chk("mix_end", {23'd0, out_q[6]}, 32'h151);
        end

        // Reset in the middle of a body: outputs drop at once, leftovers are gone.
        do_reset();
        zq.delete(); bq.delete();
        for (int k = 0; k < 8; k++) zq.push_back(8'(8'h70 + k));
        push_streams(0, 8, 0, 0, 1'b0);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 60 && !hit; c++) begin
                @(negedge clk);
                #3;
                if (out_q.size() >= 3) hit = 1'b1;
            end
            chk("midbody_reached", {31'd0, hit}, 32'd1);
        end
        chk("midbody_vld_before", {31'd0, vld_o}, 32'd1);
        rst_ni    = 1'b0;
        znz_vld_i = 1'b1;
        #1;
        chk("midrst_vld", {31'd0, vld_o}, 32'd0);
        chk("midrst_data", {24'd0, data_o}, 32'd0);
        chk("midrst_last", {31'd0, last_o}, 32'd0);
        chk("midrst_zrdy", {31'd0, znz_rdy_o}, 32'd0);
        znz_vld_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        out_q.delete();
        fd_cnt = 0;
        bq.delete();
        for (int k = 0; k < 8; k++) bq.push_back(8'(8'h60 + k));
        push_streams(0, 0, 0, 8, 1'b0);
        repeat (30) @(negedge clk);
        chk("postrst_len", out_q.size(), 9);
        if (out_q.size() == 9) begin
            chk("postrst_hdr", {23'd0, out_q[0]}, 32'h087);
            chk("postrst_w0", {23'd0, out_q[1]}, 32'h060);
            chk("postrst_w7", {23'd0, out_q[8]}, 32'h067);
        end

        // Random stalls starting from two full FIFOs.
        do_reset();
        zq.delete(); bq.delete();
        for (int k = 0; k < 40; k++) zq.push_back(8'($urandom));
        for (int k = 0; k < 40; k++) bq.push_back(8'($urandom));
        rdy_i = 1'b0;
        push_streams(0, FD, 0, FD, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("full_zrdy", {31'd0, znz_rdy_o}, 32'd0);
        chk("full_brdy", {31'd0, bpc_rdy_o}, 32'd0);
        chk("full_hdr_vld", {31'd0, vld_o}, 32'd1);
        push_streams(FD, 40, FD, 40, 1'b1);
        flush_wait(1'b1);
        reassemble_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
